ascii_msg_tx: RTL and testbench

- Transmit-side counterpart of the keypad/ASCII capture path.
- Takes a latched status code and a 16-bit packed-BCD value (account, PIN or amount), formats them as an ASCII line and streams it byte-by-byte to the terminal/UART TX over a valid/ready handshake.
- Sits between the ATM control FSM and the UART transmitter.
- Supports echo of captured digits in typed order and PIN masking.

---
 rtl/ascii_msg_tx.sv | 143 ++++++++++++++
 tb/tb_ascii_msg_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ascii_msg_tx.sv
// ascii_msg_tx: formats a status prefix plus packed-BCD digits as an ASCII line
// and streams it byte-by-byte to the UART TX over a valid/ready handshake.
module ascii_msg_tx #(
   parameter int NUM_DIGITS = 4,
   parameter bit LSD_FIRST  = 1'b1,
   parameter bit SEND_CRLF  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  status_code,
   input  logic [15:0] value,
   input  logic        mask,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFIX,
      S_DIGIT,
      S_CR,
      S_LF,
      S_DONE
   } state_t;

   localparam logic [1:0] LAST_CNT = 2'(NUM_DIGITS - 1);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [3:0]  code_q;
   logic [15:0] value_q;
   logic        mask_q;
   logic [1:0]  nib_idx;
   logic [3:0]  nibble;
   logic        xfer;

   // State and digit counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture the message inputs once, at the accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q  <= '0;
         value_q <= '0;
         mask_q  <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         code_q  <= status_code;
         value_q <= value;
         mask_q  <= mask;
      end
   end

   // Select the BCD nibble for the current digit position
   always_comb begin
      nib_idx = LSD_FIRST ? cnt_q : (LAST_CNT - cnt_q);
      case (nib_idx)
         2'd0:    nibble = value_q[3:0];
         2'd1:    nibble = value_q[7:4];
         2'd2:    nibble = value_q[11:8];
         default: nibble = value_q[15:12];
      endcase
   end

   // Next-state logic and registered-state-driven outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      xfer     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_PREFIX;
         end
         S_PREFIX: begin
            tx_valid = 1'b1;
            case (code_q)
               4'b0001: tx_data = 8'h41;
               4'b0010: tx_data = 8'h4E;
               4'b0011: tx_data = 8'h50;
               4'b0100: tx_data = 8'h58;
               4'b0101: tx_data = 8'h56;
               4'b0110: tx_data = 8'h49;
               4'b0111: tx_data = 8'h51;
               4'b1000: tx_data = 8'h4B;
               default: tx_data = 8'h3F;
            endcase
            xfer = tx_ready;
            if (xfer) begin
               state_d = S_DIGIT;
               cnt_d   = '0;
            end
         end
         S_DIGIT: begin
            tx_valid = 1'b1;
            if (mask_q || nibble > 4'd9) tx_data = 8'h2A;
            else                         tx_data = {4'h3, nibble};
            xfer = tx_ready;
            if (xfer) begin
               if (cnt_q == LAST_CNT) begin
                  state_d = SEND_CRLF ? S_CR : S_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         S_CR: begin
            tx_valid = 1'b1;
            tx_data  = 8'h0D;
            xfer     = tx_ready;
            if (xfer) state_d = S_LF;
         end
         S_LF: begin
            tx_valid = 1'b1;
            tx_data  = 8'h0A;
            xfer     = tx_ready;
            if (xfer) state_d = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ascii_msg_tx.sv
// tb_ascii_msg_tx: directed table-driven checks of ascii_msg_tx plus
// hand-written sequences for backpressure, ignored start, a reduced
// parameter set and asynchronous reset mid-message.
module tb_ascii_msg_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic        sel = 1'b0;
   logic        start, start2;
   logic [3:0]  status_code = '0;
   logic [15:0] value = '0;
   logic        mask = 1'b0;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data, tx_data2, m_data;
   logic        tx_valid, tx_valid2, m_valid;
   logic        busy, busy2, m_busy;
   logic        done, done2, m_done;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_b [8];
   int         exp_n;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] val;
      logic        msk;
      logic [7:0]  b [7];
   } vec_t;

   vec_t vecs [5];

   always #5 clk = ~clk;

   assign start  = go & ~sel;
   assign start2 = go & sel;
   assign m_data  = sel ? tx_data2  : tx_data;
   assign m_valid = sel ? tx_valid2 : tx_valid;
   assign m_busy  = sel ? busy2     : busy;
   assign m_done  = sel ? done2     : done;

   ascii_msg_tx dut (
      .clk(clk), .rst_n(rst_n), .start(start), .status_code(status_code),
      .value(value), .mask(mask), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .done(done)
   );

   ascii_msg_tx #(.NUM_DIGITS(2), .LSD_FIRST(1'b0), .SEND_CRLF(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .status_code(status_code),
      .value(value), .mask(mask), .tx_data(tx_data2), .tx_valid(tx_valid2),
      .tx_ready(tx_ready), .busy(busy2), .done(done2)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Runs one message on the selected instance. stall: hold tx_ready low 3
   // cycles before every odd-indexed byte. poke: pulse start with other
   // inputs while the message is in flight.
   task automatic run_msg(input string name, input logic [3:0] code, input logic [15:0] val,
                          input logic msk, input bit stall, input bit poke);
      int idx = 0;
      int cyc = 0;
      int stalled = 0;
      status_code = code;
      value = val;
      mask = msk;
      tx_ready = 1'b1;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      status_code = 4'b0001;
      value = 16'h1111;
      mask = ~msk;
      while (idx < exp_n && cyc < 200) begin
         go = (poke && idx == 2 && stalled == 0) ? 1'b1 : 1'b0;
         check({name, " valid"}, {15'd0, m_valid}, 16'd1);
         check({name, " data"}, {8'd0, m_data}, {8'd0, exp_b[idx]});
         if (stall && (idx % 2) == 1 && stalled < 3) begin
            tx_ready = 1'b0;
            stalled++;
         end else begin
            tx_ready = 1'b1;
            stalled = 0;
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      go = 1'b0;
      if (cyc >= 200) check({name, " timeout"}, 16'd1, 16'd0);
      check({name, " done pulse"}, {15'd0, m_done}, 16'd1);
      check({name, " done valid"}, {15'd0, m_valid}, 16'd0);
      check({name, " done busy"}, {15'd0, m_busy}, 16'd1);
      @(negedge clk);
      check({name, " idle done"}, {15'd0, m_done}, 16'd0);
      check({name, " idle busy"}, {15'd0, m_busy}, 16'd0);
      check({name, " idle valid"}, {15'd0, m_valid}, 16'd0);
   endtask

   task automatic set_exp7(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
      exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
      exp_b[4] = b4; exp_b[5] = b5; exp_b[6] = b6;
      exp_n = 7;
   endtask

   initial begin
      vecs[0] = '{4'b0001, 16'h4321, 1'b0, '{8'h41, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}};
      vecs[1] = '{4'b0011, 16'h9876, 1'b1, '{8'h50, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h0D, 8'h0A}};
      vecs[2] = '{4'b0010, 16'hF0B7, 1'b0, '{8'h4E, 8'h37, 8'h2A, 8'h30, 8'h2A, 8'h0D, 8'h0A}};
      vecs[3] = '{4'b0000, 16'h0000, 1'b0, '{8'h3F, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}};
      vecs[4] = '{4'b1000, 16'h1234, 1'b0, '{8'h4B, 8'h34, 8'h33, 8'h32, 8'h31, 8'h0D, 8'h0A}};

      repeat (2) @(negedge clk);
      check("reset valid", {15'd0, tx_valid}, 16'd0);
      check("reset busy", {15'd0, busy}, 16'd0);
      check("reset done", {15'd0, done}, 16'd0);
      check("reset data", {8'd0, tx_data}, 16'h0000);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         set_exp7(vecs[i].b[0], vecs[i].b[1], vecs[i].b[2], vecs[i].b[3],
                  vecs[i].b[4], vecs[i].b[5], vecs[i].b[6]);
         run_msg($sformatf("vec%0d", i), vecs[i].code, vecs[i].val, vecs[i].msk, 1'b0, 1'b0);
      end

      // Backpressure on every other byte
      set_exp7(8'h49, 8'h35, 8'h30, 8'h2A, 8'h30, 8'h0D, 8'h0A);
      run_msg("stall", 4'b0110, 16'h0A05, 1'b0, 1'b1, 1'b0);

      // Start pulsed while busy must not disturb the message
      set_exp7(8'h3F, 8'h38, 8'h36, 8'h34, 8'h32, 8'h0D, 8'h0A);
      run_msg("busy start", 4'b1111, 16'h2468, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("busy start not queued", {15'd0, busy}, 16'd0);

      // Reduced configuration: MSD first, 2 digits, no CR/LF
      sel = 1'b1;
      exp_b[0] = 8'h56; exp_b[1] = 8'h34; exp_b[2] = 8'h32;
      exp_n = 3;
      run_msg("msd2", 4'b0101, 16'h0042, 1'b0, 1'b0, 1'b0);
      sel = 1'b0;

      // Asynchronous reset mid-digit
      status_code = 4'b0001;
      value = 16'h5678;
      mask = 1'b0;
      tx_ready = 1'b1;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (2) @(negedge clk);
      check("pre-reset in digit", {8'd0, tx_data}, 16'h0037);
      #2 rst_n = 1'b0;
      #1;
      check("async rst valid", {15'd0, tx_valid}, 16'd0);
      check("async rst busy", {15'd0, busy}, 16'd0);
      check("async rst done", {15'd0, done}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      set_exp7(8'h58, 8'h39, 8'h30, 8'h31, 8'h32, 8'h0D, 8'h0A);
      run_msg("after reset", 4'b0100, 16'h2109, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
